// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: req/ack fetch from a variable-latency memory into IF/ID,
// with a one-entry skid buffer for responses that land while decode is stalled.
module if_fetch_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic        pc_write_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_inst_o,
    output logic [31:0] wait_cnt_o
);

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    state_e      state_q, state_d;
    fetch_t      skid_q, skid_d;
    fetch_t      ifid_q, ifid_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        accept;
    fetch_t      accept_src;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!start_i)                    state_d = imem_ack_i ? S_IDLE : S_DISCARD;
                else if (flush_i)                state_d = imem_ack_i ? S_WAIT : S_DISCARD;
                else if (imem_ack_i && stall_i)  state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!start_i)                 state_d = S_IDLE;
                else if (flush_i || !stall_i) state_d = S_WAIT;
            end
            S_DISCARD: begin
                if (imem_ack_i) state_d = start_i ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        imem_req_o  = (state_q == S_WAIT) || (state_q == S_DISCARD);
        imem_addr_o = (state_q == S_WAIT) ? pc_i : addr_q;
        accept      = start_i && !flush_i && !stall_i &&
                      (((state_q == S_WAIT) && imem_ack_i) || (state_q == S_HOLD));
        // Gating with rst_i keeps the PC frozen the instant reset asserts.
        pc_write_o  = rst_i && start_i && (accept || flush_i);
    end

    always_comb begin
        accept_src = (state_q == S_HOLD) ? skid_q : '{pc: pc_i, inst: imem_data_i};

        skid_d = skid_q;
        if ((state_q == S_WAIT) && imem_ack_i && stall_i && start_i && !flush_i) begin
            skid_d = '{pc: pc_i, inst: imem_data_i};
        end else if ((state_q == S_HOLD) && (!start_i || flush_i)) begin
            skid_d = '{pc: 32'h0, inst: NOP_INST};
        end

        // A squashed request keeps presenting its original address until the memory answers.
        addr_d = (state_q == S_WAIT) ? pc_i : addr_q;

        wait_cnt_d = wait_cnt_q;
        if (imem_req_o && !imem_ack_i) wait_cnt_d = wait_cnt_q + 32'd1;

        ifid_valid_d = ifid_valid_q;
        ifid_d       = ifid_q;
        if (!start_i || flush_i) begin
            ifid_valid_d = 1'b0;
            ifid_d       = '{pc: 32'h0, inst: NOP_INST};
        end else if (accept) begin
            ifid_valid_d = 1'b1;
            ifid_d       = accept_src;
        end else if (!stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_d.inst  = NOP_INST;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            skid_q       <= '{pc: 32'h0, inst: NOP_INST};
            ifid_q       <= '{pc: 32'h0, inst: NOP_INST};
            ifid_valid_q <= 1'b0;
            addr_q       <= 32'h0;
            wait_cnt_q   <= 32'h0;
        end else begin
            skid_q       <= skid_d;
            ifid_q       <= ifid_d;
            ifid_valid_q <= ifid_valid_d;
            addr_q       <= addr_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_inst_o  = ifid_q.inst;
    assign wait_cnt_o   = wait_cnt_q;

endmodule
